// File: rtl/wb_unit.sv
// Write-back stage: merges ALU and load results onto the register file write port and
// tracks registers with outstanding loads. Define WB_BYPASS_EN to add the write bypass outputs.
module wb_unit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic [2:0]      mem_funct3,
    input  logic [1:0]      mem_addr_lo,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      rs1_num,
    input  logic [4:0]      rs2_num,
    output logic            rs1_busy,
    output logic            rs2_busy,
`ifdef WB_BYPASS_EN
    output logic            byp_rs1_hit,
    output logic            byp_rs2_hit,
    output logic [XLEN-1:0] byp_data,
`endif
    output logic            w_enable,
    output logic [4:0]      rd_num,
    output logic [XLEN-1:0] rd_data
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;
    logic            r_wen;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_data;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;
    logic            w_alu_take;
    logic            w_rs1_hit;
    logic            w_rs2_hit;

    assign alu_ready  = !rst && !mem_valid && !r_busy[alu_rd];
    assign w_alu_take = alu_valid && alu_ready;

    always_comb begin
        w_byte = 8'h00;
        case (mem_addr_lo)
            2'd0: w_byte = mem_data[7:0];
            2'd1: w_byte = mem_data[15:8];
            2'd2: w_byte = mem_data[23:16];
            2'd3: w_byte = mem_data[31:24];
            default: w_byte = mem_data[7:0];
        endcase
        w_half = mem_addr_lo[1] ? mem_data[31:16] : mem_data[15:0];
        case (mem_funct3)
            3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
            default: w_load = mem_data;
        endcase
    end

    // Clear before set so a load issued in the same cycle keeps its register pending.
    always_comb begin
        w_busy_next = r_busy;
        if (mem_valid) begin
            w_busy_next[mem_rd] = 1'b0;
        end
        if (iss_valid) begin
            w_busy_next[iss_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_wen  <= 1'b0;
            r_rd   <= 5'd0;
            r_data <= '0;
        end else begin
            r_busy <= w_busy_next;
            if (mem_valid) begin
                r_wen <= (mem_rd != 5'd0);
                if (mem_rd != 5'd0) begin
                    r_rd   <= mem_rd;
                    r_data <= w_load;
                end
            end else if (w_alu_take) begin
                r_wen <= (alu_rd != 5'd0);
                if (alu_rd != 5'd0) begin
                    r_rd   <= alu_rd;
                    r_data <= alu_data;
                end
            end else begin
                r_wen <= 1'b0;
            end
        end
    end

    assign w_enable = r_wen;
    assign rd_num   = r_rd;
    assign rd_data  = r_data;

`ifdef WB_BYPASS_EN
    assign w_rs1_hit   = r_wen && (r_rd == rs1_num) && (rs1_num != 5'd0);
    assign w_rs2_hit   = r_wen && (r_rd == rs2_num) && (rs2_num != 5'd0);
    assign byp_rs1_hit = w_rs1_hit;
    assign byp_rs2_hit = w_rs2_hit;
    assign byp_data    = r_data;
`else
    assign w_rs1_hit = 1'b0;
    assign w_rs2_hit = 1'b0;
`endif

    assign rs1_busy = !rst && r_busy[rs1_num] && !w_rs1_hit;
    assign rs2_busy = !rst && r_busy[rs2_num] && !w_rs2_hit;

endmodule

// File: tb/tb_wb_unit.sv
// Scoreboard bench for wb_unit: stimulus pushes expected writes, a negedge monitor pops and
// compares every register file write.
module tb_wb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic        iss_valid;
    logic [4:0]  iss_rd, rs1_num, rs2_num;
    logic        rs1_busy, rs2_busy;
    logic        w_enable;
    logic [4:0]  rd_num;
    logic [31:0] rd_data;
`ifdef WB_BYPASS_EN
    logic        byp_rs1_hit, byp_rs2_hit;
    logic [31:0] byp_data;
`endif

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    always #5 clk = ~clk;

    wb_unit dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rs1_num(rs1_num), .rs2_num(rs2_num), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef WB_BYPASS_EN
        .byp_rs1_hit(byp_rs1_hit), .byp_rs2_hit(byp_rs2_hit), .byp_data(byp_data),
`endif
        .w_enable(w_enable), .rd_num(rd_num), .rd_data(rd_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Settle and sample mid-cycle.
    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (w_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got rd=%0d data=%h expected no write",
                         rd_num, rd_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_rd", {27'd0, rd_num}, {27'd0, e.rd});
                check("wr_data", rd_data, e.data);
            end
        end
    end

    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                        input logic [31:0] exp);
        mem_valid   = 1'b1;
        mem_rd      = rd;
        mem_funct3  = f3;
        mem_addr_lo = lo;
        push(rd, exp);
        tick();
        mem_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'h0; mem_funct3 = 3'b010;
        mem_addr_lo = 2'd0;
        iss_valid = 1'b1; iss_rd = 5'd5; rs1_num = 5'd5; rs2_num = 5'd0;

        // Reset with live inputs: nothing may be accepted or recorded.
        tick();
        at_neg();
        check("rst_ready", {31'd0, alu_ready}, 32'd0);
        check("rst_wen", {31'd0, w_enable}, 32'd0);
        check("rst_rd_num", {27'd0, rd_num}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_busy", {31'd0, rs1_busy}, 32'd0);
        tick();
        alu_valid = 1'b0; iss_valid = 1'b0;
        rst = 1'b0;
        at_neg();
        check("post_rst_busy", {31'd0, rs1_busy}, 32'd0);

        // Plain ALU write.
        tick();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
        at_neg();
        check("alu_ready", {31'd0, alu_ready}, 32'd1);
        push(5'd3, 32'hDEADBEEF);
        tick();
        alu_valid = 1'b0;
        at_neg();
        tick();
        at_neg();
        check("wen_drop", {31'd0, w_enable}, 32'd0);
        check("hold_rd", {27'd0, rd_num}, 32'd3);

        // Load alignment and extension.
        tick();
        mem_data = 32'h80FF7F01;
        load(5'd10, 3'b000, 2'd3, 32'hFFFFFF80);
        load(5'd11, 3'b100, 2'd1, 32'h0000007F);
        load(5'd12, 3'b001, 2'd2, 32'hFFFF80FF);
        load(5'd13, 3'b101, 2'd2, 32'h000080FF);
        load(5'd14, 3'b101, 2'd3, 32'h000080FF);
        load(5'd15, 3'b010, 2'd1, 32'h80FF7F01);
        load(5'd16, 3'b111, 2'd0, 32'h80FF7F01);

        // Scoreboard stall on a pending load.
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0; rs1_num = 5'd7;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h00000077;
        at_neg();
        check("sb_busy", {31'd0, rs1_busy}, 32'd1);
        check("sb_stall0", {31'd0, alu_ready}, 32'd0);
        tick();
        at_neg();
        check("sb_stall1", {31'd0, alu_ready}, 32'd0);
        mem_data = 32'hAAAA0007;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_funct3 = 3'b010; mem_addr_lo = 2'd0;
        push(5'd7, 32'hAAAA0007);
        #1;
        check("sb_stall_mem", {31'd0, alu_ready}, 32'd0);
        tick();
        mem_valid = 1'b0;
        at_neg();
        check("sb_clear", {31'd0, rs1_busy}, 32'd0);
        check("sb_ready", {31'd0, alu_ready}, 32'd1);
        push(5'd7, 32'h00000077);
        tick();
        alu_valid = 1'b0;

        // Same-cycle mem and ALU: mem first.
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44444444;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99999999;
        at_neg();
        check("cf_ready0", {31'd0, alu_ready}, 32'd0);
        push(5'd4, 32'h44444444);
        tick();
        mem_valid = 1'b0;
        at_neg();
        check("cf_ready1", {31'd0, alu_ready}, 32'd1);
        push(5'd9, 32'h99999999);
        tick();

        // x0 destinations: consumed, never written, never busy.
        alu_rd = 5'd0; alu_data = 32'h0BADF00D;
        at_neg();
        check("x0_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd0; iss_valid = 1'b1; iss_rd = 5'd0;
        tick();
        mem_valid = 1'b0; iss_valid = 1'b0; rs1_num = 5'd0;
        at_neg();
        check("x0_busy", {31'd0, rs1_busy}, 32'd0);
        check("x0_hold", rd_data, 32'h99999999);

        // Same-cycle issue and return on r6: set wins.
        iss_valid = 1'b1; iss_rd = 5'd6;
        tick();
        mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h00000066;
        push(5'd6, 32'h00000066);
        tick();
        mem_valid = 1'b0; iss_valid = 1'b0; rs1_num = 5'd6; rs2_num = 5'd6;
        at_neg();
`ifdef WB_BYPASS_EN
        check("byp_hit", {31'd0, byp_rs1_hit}, 32'd1);
        check("byp_data", byp_data, 32'h00000066);
        check("byp_busy", {31'd0, rs1_busy}, 32'd0);
`else
        check("sc_busy_w", {31'd0, rs1_busy}, 32'd1);
`endif
        tick();
        at_neg();
        check("sc_busy", {31'd0, rs2_busy}, 32'd1);
        mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h00006666;
        push(5'd6, 32'h00006666);
        tick();
        mem_valid = 1'b0;
        tick();
        at_neg();
        check("sc_clear", {31'd0, rs2_busy}, 32'd0);

        tick();
        tick();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Write-back stage that drives the general register file write port (w_enable, rd_num, rd_data).
- Merges results from two producers:
  - the single-cycle ALU;
  - the load path, which returns raw 32-bit bus words that this block aligns and extends.
- Keeps a scoreboard of registers with an outstanding load, and exposes busy flags to the decoder for hazard stalls.
- Sits between the ALU and load unit on one side and the register file on the other.

Parameters:
- XLEN, 32, data width of result and register file.
- NREG, 32, number of architectural registers; index width is 5.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result present
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- mem_valid  in  1  load data returning
- mem_rd  in  5  load destination register
- mem_data  in  32  raw aligned bus word
- mem_funct3  in  3  load type (RISC-V funct3)
- mem_addr_lo  in  2  load address bits [1:0]
- iss_valid  in  1  load issued this cycle
- iss_rd  in  5  destination of issued load
- rs1_num  in  5  decoder source 1 index
- rs2_num  in  5  decoder source 2 index
- rs1_busy  out  1  rs1 awaits an outstanding load
- rs2_busy  out  1  rs2 awaits an outstanding load
- w_enable  out  1  register file write enable
- rd_num  out  5  register file write index
- rd_data  out  32  register file write data

Behaviour:
- Reset values: w_enable=0, rd_num=0, rd_data=0, busy vector all 0.
- While rst=1:
  - alu_ready=0;
  - rs1_busy=0 and rs2_busy=0;
  - all inputs are ignored, and loads returning or issued in that cycle are dropped.
- Priority and acceptance:
  - mem_valid has absolute priority; the load path has no ready and is always consumed.
  - alu_ready = !rst && !mem_valid && !busy[alu_rd] (combinational).
  - An ALU result is consumed when alu_valid && alu_ready. An ALU writer to a register with a pending load waits, which preserves WAW order.
- Latency:
  - A consumed result appears on rd_num/rd_data exactly 1 cycle later, registered.
  - w_enable=1 for exactly that one cycle, unless the destination is x0.
  - rd_num/rd_data hold their last value when w_enable=0.
- x0 handling: a result with rd=0 is consumed but produces w_enable=0, and never sets or clears busy.
- Load extension, by mem_funct3, with byte offset o=mem_addr_lo:
  - 000 LB: sign-extend mem_data[8o+7:8o].
  - 100 LBU: zero-extend mem_data[8o+7:8o].
  - 001 LH: sign-extend the halfword at mem_addr_lo[1] (bit 0 ignored).
  - 101 LHU: zero-extend the halfword at mem_addr_lo[1] (bit 0 ignored).
  - 010 LW and all other codes: mem_data unchanged.
- Scoreboard (busy[NREG-1:0]):
  - iss_valid && iss_rd!=0 sets busy[iss_rd] at the clock edge.
  - A consumed mem result clears busy[mem_rd] at the clock edge.
  - Set and clear of the same index in the same cycle: set wins (a new load is pending).
  - busy[0] is constantly 0.
- Busy outputs: rs1_busy=busy[rs1_num] and rs2_busy=busy[rs2_num], combinational from current state. The clear takes effect the cycle after the mem result is accepted, which is the same cycle the write is presented.
- Simultaneous mem_valid and alu_valid: mem is written, and the ALU holds alu_valid with alu_ready=0 until the next cycle.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - Extra outputs byp_rs1_hit (1), byp_rs2_hit (1), byp_data (32).
  - byp_rsN_hit = w_enable && rd_num==rsN_num && rsN_num!=0.
  - byp_data = rd_data.
  - This lets the decoder read the value being written this cycle, before the register file updates.
  - When a hit occurs, rsN_busy is forced to 0 for that cycle.
- Undefined: the extra outputs do not exist, and there is no busy override.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with alu_valid=1, alu_rd=5, alu_data=32'h1234.
  - Required: w_enable stays 0, alu_ready=0, and the busy flags stay 0 after release.
- ALU write:
  - Stimulus: alu_valid, alu_rd=3, alu_data=32'hDEADBEEF.
  - Required: next cycle w_enable=1, rd_num=3, rd_data=32'hDEADBEEF; the cycle after that, w_enable=0.
- Load extension:
  - Stimulus: mem_data=32'h80FF7F01 with LB at o=3, LBU at o=1, LH at o=2, LHU at o=2.
  - Required rd_data: 32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h000080FF respectively.
- Scoreboard:
  - Stimulus: iss_valid, iss_rd=7, then rs1_num=7.
  - Required: rs1_busy=1.
  - Stimulus: alu_valid, alu_rd=7.
  - Required: alu_ready=0 until the mem result for rd=7 is accepted; then busy clears and the ALU write follows in the next cycles.
- Conflict:
  - Stimulus: mem_valid (rd=4) and alu_valid (rd=9) in the same cycle.
  - Required: write rd=4 first, then rd=9 on the following cycle.
  - Stimulus: rd=0 on either source.
  - Required: never w_enable.
- Same-cycle set/clear:
  - Stimulus: iss_rd=6 issued in the same cycle a mem result for rd=6 returns.
  - Required: busy[6] stays 1.
  - With WB_BYPASS_EN: rs1_num matching rd_num gives byp_rs1_hit=1 and byp_data=rd_data.
